// File: rtl/seq_serializer.sv
// Parallel-to-serial front end with a one-word holding buffer so words stream back to back.
// Optional build macro SER_LSB_FIRST_EN sends bit 0 first; the default sends bit WIDTH-1 first.
module seq_serializer #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_shift;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic             busy_q, busy_d;
  logic             load_ready_q, load_ready_d;
  logic             accept, last;

  // Next state; outputs are registered from the next-state values so they line up with sh/cnt.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_d       = cnt_q;
    accept      = load_valid && load_ready_q;
    last        = (cnt_q == CNT_LAST);
`ifdef SER_LSB_FIRST_EN
    sh_shift    = {1'b0, sh_q[WIDTH-1:1]};
`else
    sh_shift    = {sh_q[WIDTH-2:0], 1'b0};
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          cnt_d = '0;
          if (pend_full_q) begin
            sh_d        = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            sh_d = load_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          sh_d  = sh_shift;
          if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ser_valid_d  = (state_d == SHIFT);
`ifdef SER_LSB_FIRST_EN
    ser_out_d    = ser_valid_d ? sh_d[0] : IDLE_BIT;
`else
    ser_out_d    = ser_valid_d ? sh_d[WIDTH-1] : IDLE_BIT;
`endif
    word_done_d  = ser_valid_d && (cnt_d == CNT_LAST);
    busy_d       = ser_valid_d || pend_full_d;
    load_ready_d = !pend_full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      cnt_q        <= '0;
      ser_out_q    <= IDLE_BIT;
      ser_valid_q  <= 1'b0;
      word_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      pend_q       <= pend_d;
      pend_full_q  <= pend_full_d;
      cnt_q        <= cnt_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      word_done_q  <= word_done_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign load_ready = load_ready_q;
  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign word_done  = word_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: directed cases plus random traffic against a bit-queue reference model.
module tb_seq_serializer;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] load_data = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, ser_out, ser_valid, word_done, busy;

  int n_vec = 0;
  int n_err = 0;
  logic last_acc = 1'b0;

  // Model: every bit still owed on the line, tagged {last_bit_of_word, data_bit}.
  logic [1:0] mq[$];

  seq_serializer #(.WIDTH(W), .IDLE_BIT(1'b1)) dut (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .word_done(word_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [W-1:0] w, input int k);
`ifdef SER_LSB_FIRST_EN
    return w[k];
`else
    return w[W-1-k];
`endif
  endfunction

  // One clock: update model at the rising edge, compare DUT outputs at the falling edge.
  task automatic cycle();
    logic acc;
    int   sz;
    @(posedge clk);
    acc = load_valid && (mq.size() <= int'(W)) && !reset;
    last_acc = acc;
    if (mq.size() > 0) void'(mq.pop_front());
    if (acc)
      for (int k = 0; k < int'(W); k++) mq.push_back({k == int'(W) - 1, bit_of(load_data, k)});
    if (reset) mq.delete();
    @(negedge clk);
    sz = mq.size();
    check("ser_valid",  32'(ser_valid),  32'(sz > 0));
    check("ser_out",    32'(ser_out),    32'((sz > 0) ? mq[0][0] : 1'b1));
    check("word_done",  32'(word_done),  32'((sz > 0) ? mq[0][1] : 1'b0));
    check("busy",       32'(busy),       32'(sz > 0));
    check("load_ready", 32'(load_ready), 32'(sz <= int'(W)));
  endtask

  // Offer a word and hold it until accepted, with a bounded wait.
  task automatic send_hold(input logic [W-1:0] w);
    int n;
    load_valid = 1'b1;
    load_data  = w;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 4 * int'(W));
    if (!last_acc) check("accept_timeout", 32'(0), 32'(1));
    load_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0]   cap8, wd8;
    logic [2*W-1:0] cap16, val16, wd16;

    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // Single word: 8'h24 is a palindrome, so both bit orders give the same stream.
    send_hold(8'h24);
    cap8 = '0;
    wd8  = '0;
    for (int i = 0; i < int'(W); i++) begin
      cap8 = {cap8[W-2:0], ser_out};
      wd8  = {wd8[W-2:0], word_done};
      cycle();
    end
    check("single_stream", 32'(cap8), 32'(8'h24));
    check("single_wdone",  32'(wd8),  32'(8'h01));
    check("single_idle",   32'({ser_out, ser_valid, busy}), 32'(3'b100));
    repeat (3) cycle();

    // Back-to-back: second word offered while the first is shifting.
    send_hold(8'h24);
    cap16 = '0;
    val16 = '0;
    wd16  = '0;
    for (int i = 0; i < 2 * int'(W); i++) begin
      cap16 = {cap16[2*W-2:0], ser_out};
      val16 = {val16[2*W-2:0], ser_valid};
      wd16  = {wd16[2*W-2:0], word_done};
      if (i == 2) begin
        load_valid = 1'b1;
        load_data  = 8'h81;
      end
      cycle();
      load_valid = 1'b0;
    end
    check("b2b_stream", 32'(cap16), 32'(16'h2481));
    check("b2b_valid",  32'(val16), 32'(16'hFFFF));
    check("b2b_wdone",  32'(wd16),  32'(16'h0101));
    repeat (2) cycle();

    // Backpressure: valid held high across three words.
    send_hold(8'hA5);
    send_hold(8'h3C);
    check("bp_ready_low", 32'(load_ready), 32'(0));
    send_hold(8'hF0);
    repeat (3 * W) cycle();

    // Reset in the 4th bit of a word with the holding buffer full.
    send_hold(8'hC3);
    send_hold(8'h5A);
    repeat (2) cycle();
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    cycle();
    reset      = 1'b0;
    load_valid = 1'b0;
    check("rst_outputs", 32'({ser_out, ser_valid, busy, load_ready, word_done}), 32'(5'b10010));

    // Idle line after reset.
    repeat (20) cycle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      load_valid = ($urandom % 4) != 0;
      load_data  = W'($urandom);
      reset      = ($urandom % 200) == 0;
      cycle();
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    repeat (3 * W) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
